// File: rtl/ladybird_inst_builder.sv
// ladybird_inst_builder: encodes abstract ADDI/LOAD/STORE/LI/JAL commands into RV32I/RV64I words and queues them.
// Latency: a word accepted on edge N is visible at out_inst/out_valid after edge N; a two-word LI adds its ADDI one cycle later.
// Backpressure: cmd_ready needs IDLE, two free FIFO slots and no flush; out_inst holds the head until out_ready pops it.
//
// Ports: clk/nrst (async active-low); cmd_* valid/ready command input; flush clears queue and FSM;
//        out_valid/out_ready/out_inst FIFO head; count = occupancy; err = one-cycle pulse after an illegal command.

// fifo_sync: generic DEPTH-entry register FIFO with synchronous clear.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes into a full FIFO and pops from an empty one are ignored; clr wins over push/pop.
module fifo_sync #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         out_vld,
    output logic [W-1:0]                 out_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_vld && (count != DEPTH_C);
    assign do_pop  = pop_rdy && (count != '0);
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ladybird_inst_builder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [1:0]                  cmd_size,
    input  logic [4:0]                  cmd_rd,
    input  logic [4:0]                  cmd_rs,
    input  logic [XLEN-1:0]             cmd_imm,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_inst,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_ADDI  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_LOADU = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_LI    = 3'd4;
    localparam logic [2:0] OP_JAL   = 3'd5;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    typedef enum logic {IDLE, EMIT2} state_t;

    state_t        state;
    logic [31:0]   pend_word;
    logic [CW-1:0] free_cnt;
    logic          fire;

    logic          illegal;
    logic          two_word;
    logic          fits12;
    logic          fits32;
    logic [19:0]   lui_hi;
    logic [31:0]   enc_word;
    logic [31:0]   second_word;

    logic          push_vld;
    logic [31:0]   push_dat;
    logic          pop_rdy;

    // Two free slots are demanded so the ADDI half of an LI always has room.
    assign free_cnt  = DEPTH_C - count;
    assign cmd_ready = nrst && (state == IDLE) && (free_cnt >= CW'(2)) && !flush;
    assign fire      = cmd_valid && cmd_ready;

    always_comb begin
        illegal     = 1'b0;
        two_word    = 1'b0;
        enc_word    = '0;
        second_word = '0;
        fits12      = (&cmd_imm[XLEN-1:11]) || !(|cmd_imm[XLEN-1:11]);
        fits32      = (&cmd_imm[XLEN-1:31]) || !(|cmd_imm[XLEN-1:31]);
        // ADDI sign-extends its 12-bit immediate, so LUI pre-adds bit 11 to compensate.
        lui_hi      = cmd_imm[31:12] + {19'b0, cmd_imm[11]};

        if ((XLEN == 32) && (cmd_size == 2'd3)) begin
            illegal = 1'b1;
        end

        case (cmd_op)
            OP_ADDI: begin
                enc_word = {cmd_imm[11:0], cmd_rs, 3'b000, cmd_rd, OPC_OPIMM};
            end
            OP_LOAD: begin
                enc_word = {cmd_imm[11:0], cmd_rs, {1'b0, cmd_size}, cmd_rd, OPC_LOAD};
            end
            OP_LOADU: begin
                enc_word = {cmd_imm[11:0], cmd_rs, {1'b1, cmd_size}, cmd_rd, OPC_LOAD};
                // No LDU exists, and LWU only exists on RV64.
                if ((cmd_size == 2'd3) || ((XLEN == 32) && (cmd_size == 2'd2))) begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                enc_word = {cmd_imm[11:5], cmd_rd, cmd_rs, {1'b0, cmd_size}, cmd_imm[4:0], OPC_STORE};
            end
            OP_LI: begin
                if (!fits32) begin
                    illegal = 1'b1;
                end else if (fits12) begin
                    enc_word = {cmd_imm[11:0], 5'd0, 3'b000, cmd_rd, OPC_OPIMM};
                end else begin
                    two_word    = 1'b1;
                    enc_word    = {lui_hi, cmd_rd, OPC_LUI};
                    second_word = {cmd_imm[11:0], cmd_rd, 3'b000, cmd_rd, OPC_OPIMM};
                end
            end
            OP_JAL: begin
                enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OPC_JAL};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            pend_word <= '0;
            err       <= 1'b0;
        end else begin
            err <= fire && illegal;
            if (flush) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (fire && !illegal && two_word) begin
                    state     <= EMIT2;
                    pend_word <= second_word;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    assign push_vld = (fire && !illegal) || ((state == EMIT2) && !flush);
    assign push_dat = (state == EMIT2) ? pend_word : enc_word;
    assign pop_rdy  = out_ready && !flush;

    fifo_sync #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (flush),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .out_vld  (out_valid),
        .out_dat  (out_inst),
        .count    (count)
    );
endmodule

// File: tb/tb_ladybird_inst_builder.sv
// tb_ladybird_inst_builder: directed vectors with hand-computed instruction words.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: out_ready is held low to fill the queue, then toggled for push/pop and drain.
module tb_ladybird_inst_builder;
    logic        clk;
    logic        nrst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_size;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs;
    logic [31:0] cmd_imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [3:0]  count;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    ladybird_inst_builder #(
        .XLEN  (32),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_size  (cmd_size),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_imm   (cmd_imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .count     (count),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // ADDI x1, x0, imm
    function automatic logic [31:0] addi_w(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    // Present a command, wait (bounded) for acceptance, return on the falling edge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [31:0] imm);
        int n;
        cmd_op    = op;
        cmd_size  = sz;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("rdy_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, out_inst, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_size  = '0;
        cmd_rd    = '0;
        cmd_rs    = '0;
        cmd_imm   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        #9 nrst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 32'd1);

        // ADDI x1, x0, 5
        send(3'd0, 2'd0, 5'd1, 5'd0, 32'd5);
        chk("addi_count1", 32'(count), 32'd1);
        pop_chk("addi", 32'h00500093);
        chk("addi_count0", 32'(count), 32'd0);
        chk("addi_empty", 32'(out_valid), 32'd0);

        // LB / SB / LHU with rd=2 rs=3 imm=4
        send(3'd1, 2'd0, 5'd2, 5'd3, 32'd4);
        send(3'd3, 2'd0, 5'd2, 5'd3, 32'd4);
        send(3'd2, 2'd1, 5'd2, 5'd3, 32'd4);
        chk("ls_count", 32'(count), 32'd3);
        pop_chk("lb", 32'h00418103);
        pop_chk("sb", 32'h00218223);
        pop_chk("lhu", 32'h0041D103);

        // Two-word LI: LUI then ADDI on consecutive cycles
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'h12345FFF);
        chk("li_cnt1", 32'(count), 32'd1);
        chk("li_emit2_rdy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("li_cnt2", 32'(count), 32'd2);
        chk("li_idle_rdy", 32'(cmd_ready), 32'd1);
        pop_chk("li_lui", 32'h123462B7);
        pop_chk("li_addi", 32'hFFF28293);

        // Single-word LI at both 12-bit limits
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'h000007FF);
        @(negedge clk);
        chk("li7ff_cnt", 32'(count), 32'd1);
        pop_chk("li7ff", 32'h7FF00293);
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'hFFFFF800);
        @(negedge clk);
        chk("lineg_cnt", 32'(count), 32'd1);
        pop_chk("lineg", 32'h80000293);

        // LI with imm[11]=0 needs no rounding in LUI
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'h00001000);
        @(negedge clk);
        pop_chk("li1k_lui", 32'h000012B7);
        pop_chk("li1k_addi", 32'h00028293);

        // JAL
        send(3'd5, 2'd0, 5'd1, 5'd0, 32'd8);
        pop_chk("jal8", 32'h008000EF);
        send(3'd5, 2'd0, 5'd1, 5'd0, 32'h00000800);
        pop_chk("jal800", 32'h001000EF);

        // Illegal op and illegal size: consumed, nothing pushed, one-cycle err
        send(3'd6, 2'd0, 5'd1, 5'd0, 32'd1);
        chk("ill_op_err", 32'(err), 32'd1);
        chk("ill_op_cnt", 32'(count), 32'd0);
        @(negedge clk);
        chk("ill_op_err_clr", 32'(err), 32'd0);
        send(3'd0, 2'd3, 5'd1, 5'd0, 32'd1);
        chk("ill_sz_err", 32'(err), 32'd1);
        chk("ill_sz_cnt", 32'(count), 32'd0);
        @(negedge clk);
        chk("ill_sz_err_clr", 32'(err), 32'd0);
        send(3'd2, 2'd2, 5'd1, 5'd0, 32'd1);
        chk("ill_lwu_err", 32'(err), 32'd1);
        chk("ill_lwu_cnt", 32'(count), 32'd0);

        // Fill with out_ready low: ready drops at count 7
        for (int i = 0; i < 7; i++) begin
            send(3'd0, 2'd0, 5'd1, 5'd0, 32'(i + 1));
            exp_q.push_back(addi_w(12'(i + 1)));
        end
        chk("fill_cnt", 32'(count), 32'd7);
        chk("fill_rdy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("fill_hold", out_inst, exp_q[0]);
        pop_chk("fill_head", exp_q.pop_front());
        chk("fill_cnt6", 32'(count), 32'd6);

        // Simultaneous push/pop: count holds, order survives pointer wrap
        for (int k = 0; k < 10; k++) begin
            chk("wrap_head", out_inst, exp_q[0]);
            cmd_op    = 3'd0;
            cmd_size  = 2'd0;
            cmd_rd    = 5'd1;
            cmd_rs    = 5'd0;
            cmd_imm   = 32'(100 + k);
            cmd_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            void'(exp_q.pop_front());
            exp_q.push_back(addi_w(12'(100 + k)));
            chk("wrap_cnt", 32'(count), 32'd6);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        while (exp_q.size() > 0) begin
            pop_chk("drain", exp_q.pop_front());
        end
        chk("drain_cnt", 32'(count), 32'd0);

        // flush during EMIT2 with count=3
        send(3'd0, 2'd0, 5'd1, 5'd0, 32'd1);
        send(3'd0, 2'd0, 5'd1, 5'd0, 32'd2);
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'h12345FFF);
        chk("fl_cnt3", 32'(count), 32'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fl_cnt0", 32'(count), 32'd0);
        chk("fl_vld0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("fl_no_addi", 32'(count), 32'd0);
        chk("fl_rdy", 32'(cmd_ready), 32'd1);

        // Reset mid-LI
        send(3'd0, 2'd0, 5'd1, 5'd0, 32'd3);
        send(3'd4, 2'd0, 5'd5, 5'd0, 32'h12345FFF);
        chk("mr_cnt2", 32'(count), 32'd2);
        #2 nrst = 1'b0;
        #1;
        chk("mr_cnt", 32'(count), 32'd0);
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_inst", out_inst, 32'h0);
        chk("mr_rdy", 32'(cmd_ready), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        chk("mr_lost", 32'(count), 32'd0);
        chk("mr_lost_vld", 32'(out_valid), 32'd0);
        chk("mr_rdy_back", 32'(cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ladybird_inst_builder.md
Name: ladybird_inst_builder

Overview:
Sequential RISC-V instruction assembler and queue. Takes abstract commands (ADDI, load, store, load-immediate, JAL) over a valid/ready interface, encodes them into RV32I/RV64I instruction words, and buffers them in a DEPTH-entry FIFO. Feeds a core fetch port or debug program buffer. Generalises the fixed byte-wide LB/SB/ADDI/JAL constructors to all access sizes, unsigned loads, and full-XLEN immediates (LUI+ADDI expansion).

Parameters:
XLEN, 32, 32 or 64; enables doubleword access when 64
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  3  0 ADDI, 1 LOAD, 2 LOADU, 3 STORE, 4 LI, 5 JAL, 6-7 illegal
cmd_size  in  2  0 byte, 1 half, 2 word, 3 double
cmd_rd  in  5  destination reg (STORE: data source rs2)
cmd_rs  in  5  base/source reg rs1
cmd_imm  in  XLEN  immediate / offset / LI value
flush  in  1  synchronous queue and FSM clear
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pop
out_inst  out  32  instruction at FIFO head
count  out  $clog2(DEPTH+1)  occupied entries
err  out  1  one-cycle pulse, illegal command consumed

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, nrst.
- Reset: FIFO empty, FSM IDLE. out_valid=0, count=0, err=0, out_inst=0, cmd_ready=0 while nrst low.
- cmd_ready = (state==IDLE) && (DEPTH-count >= 2) && !flush. Two free entries are always required, so an LI second word never stalls.
- Encodings (imm = cmd_imm):
  - ADDI: {imm[11:0], rs, 000, rd, 0010011}
  - LOAD: funct3 = {0,size}, opcode 0000011
  - LOADU: funct3 = {1,size}
  - STORE: {imm[11:5], rd, rs, {0,size}, imm[4:0], 0100011}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}; imm[0] ignored.
- LI:
  - If imm[XLEN-1:11] is all equal (fits signed 12 bits): one word, ADDI rd, x0, imm[11:0].
  - Otherwise: LUI rd, (imm[31:12] + imm[11]) (opcode 0110111, 20-bit wrap), then next cycle ADDI rd, rd, imm[11:0].
  - For XLEN=64, only imm[31:0] is encoded; upper bits must be the sign extension, else illegal.
- Illegal commands: op 6/7; size 3 when XLEN=32; LOADU with size 2 when XLEN=32; LOADU with size 3. They are consumed (handshake completes), nothing is pushed, and err pulses the following cycle.
- FSM:
  - IDLE: accept; push first word same edge.
  - IDLE -> EMIT2 on a two-word LI.
  - EMIT2: cmd_ready=0; push the latched ADDI; -> IDLE.
- Latency: accept at edge N means the word is visible on out_inst/out_valid after edge N (registered FIFO). Empty-to-valid takes 1 cycle.
- Push and pop in the same cycle are allowed: count is unchanged, pointers wrap modulo DEPTH.
- out_inst holds the head while out_valid && !out_ready. It is undefined (hold last) when empty.
- flush: next edge empties the FIFO, forces IDLE, and discards a pending EMIT2 word. A same-cycle pop is ignored. flush dominates.
- Reset mid-LI: pending second word lost; FIFO empty.

Test Plan:
- ADDI rd=1, rs=0, imm=5 -> single pop 0x00500093; count 1 -> 0.
- LOAD size0 rd=2 rs=3 imm=4 -> 0x00418103; STORE size0 rd=2 rs=3 imm=4 -> 0x00218223; LOADU size1 rd=2 rs=3 imm=4 -> 0x0041D103.
- LI rd=5 imm=0x12345FFF -> 0x123462B7 then 0xFFF28293 on consecutive cycles; cmd_ready low during EMIT2. LI rd=5 imm=0x7FF -> single 0x7FF00293.
- JAL rd=1 imm=8 -> 0x008000EF. op=6 or size=3 (XLEN=32) -> no push, err high exactly one cycle.
- Fill with out_ready=0 (DEPTH=8): cmd_ready drops at count=7. Then simultaneous push/pop holds count and FIFO order is preserved across pointer wrap.
- flush during EMIT2 with count=3 -> next cycle count=0, out_valid=0, no ADDI emitted. nrst pulse mid-stream -> all outputs return to reset values immediately.
